// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        WRITE,
        CHECK
    } state_t;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int unsigned WORD_WIDTH        = 16;

endpackage

// File: rtl/imem_loader_checksum.sv
// 8-bit additive checksum accumulator with clear, add-enable and compare.
module loader_checksum (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_clear,
    input  logic       i_add,
    input  logic [7:0] i_byte,
    input  logic [7:0] i_expect,
    output logic       o_match
);

    logic [7:0] r_sum;

    // Running mod-256 sum; clear wins over add.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_byte;
        end
    end

    assign o_match = (r_sum == i_expect);

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream program loader writing 16-bit words into instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] im_address,
    output logic [WORD_WIDTH-1:0] im_data,
    output logic                  im_wren,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [15:0]           words_loaded
);

    // Largest legal word count: the full memory.
    localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

    state_t                r_state;
    state_t                w_next;
    logic [7:0]            r_len_hi;
    logic [15:0]           r_len;
    logic [WORD_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_words;
    logic                  r_ready;
    logic                  r_wren;
    logic                  r_hold;
    logic                  r_done;
    logic                  r_error;

    logic                  w_xfer;
    logic [15:0]           w_len_new;
    logic                  w_start;
    logic                  w_csum_add;
    logic                  w_len_bad;
    logic                  w_ok;
    logic                  w_bad_csum;
    logic                  w_match;

    assign w_xfer    = rx_valid && r_ready;
    assign w_len_new = {r_len_hi, rx_data};

    loader_checksum u_checksum (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (w_start),
        .i_add    (w_csum_add),
        .i_byte   (rx_data),
        .i_expect (rx_data),
        .o_match  (w_match)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-transfer event strobes.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_csum_add = 1'b0;
        w_len_bad  = 1'b0;
        w_ok       = 1'b0;
        w_bad_csum = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_xfer && rx_data == SYNC_BYTE) begin
                    w_start = 1'b1;
                    w_next  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (w_xfer) w_next = LEN_LO;
            end
            LEN_LO: begin
                if (w_xfer) begin
                    if (w_len_new == '0) begin
                        w_next = CHECK;
                    end else if ({1'b0, w_len_new} > MAX_WORDS) begin
                        w_len_bad = 1'b1;
                        w_next    = IDLE;
                    end else begin
                        w_next = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (w_xfer) begin
                    w_csum_add = 1'b1;
                    w_next     = DATA_LO;
                end
            end
            DATA_LO: begin
                if (w_xfer) begin
                    w_csum_add = 1'b1;
                    w_next     = WRITE;
                end
            end
            WRITE: begin
                w_next = (r_words + 16'd1 == r_len) ? CHECK : DATA_HI;
            end
            CHECK: begin
                if (w_xfer) begin
                    w_ok       = w_match;
                    w_bad_csum = !w_match;
                    w_next     = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; ready/wren are decoded from the next state
    // so both are glitch-free and independent of rx_valid within the cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_len_hi <= '0;
            r_len    <= '0;
            r_data   <= '0;
            r_addr   <= '0;
            r_words  <= '0;
            r_ready  <= 1'b0;
            r_wren   <= 1'b0;
            r_hold   <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_ready <= (w_next != WRITE);
            r_wren  <= (w_next == WRITE);
            r_done  <= w_ok;
            if (w_start) begin
                r_error <= 1'b0;
                r_words <= '0;
                r_addr  <= '0;
                r_hold  <= 1'b1;
            end
            if (w_xfer && r_state == LEN_HI)  r_len_hi     <= rx_data;
            if (w_xfer && r_state == LEN_LO)  r_len        <= w_len_new;
            if (w_xfer && r_state == DATA_HI) r_data[15:8] <= rx_data;
            if (w_xfer && r_state == DATA_LO) r_data[7:0]  <= rx_data;
            if (r_state == WRITE) begin
                r_addr  <= r_addr + ADDR_WIDTH'(1);
                r_words <= r_words + 16'd1;
            end
            if (w_len_bad || w_bad_csum) r_error <= 1'b1;
            if (w_ok) r_hold <= 1'b0;
        end
    end

    assign rx_ready     = r_ready;
    assign im_address   = r_addr;
    assign im_data      = r_data;
    assign im_wren      = r_wren;
    assign cpu_hold     = r_hold;
    assign load_done    = r_done;
    assign load_error   = r_error;
    assign words_loaded = r_words;

endmodule
